// File: rtl/somador_serial_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// somador_serial_ctrl_pkg
//
// Shared definitions for the multi-cycle datapath controllers. The state
// encoding below is common to every controller that follows the
// start -> run -> done handshake, so the encodings must stay fixed:
//   IDLE = 2'b00  waiting for start
//   RUN  = 2'b01  multi-cycle operation in progress (busy)
//   DONE = 2'b10  single-cycle completion pulse (done)
// ----------------------------------------------------------------------------
package somador_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mc_state_e;

endpackage : somador_serial_ctrl_pkg

// File: rtl/somador_bit.sv
// ----------------------------------------------------------------------------
// somador_bit
//
// Structural 1-bit full adder built from gate primitives. It is the only
// arithmetic cell of the bit-serial adder/subtractor.
//
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit        = a ^ b ^ cin
//   cout  out  carry out      = a&b | (a^b)&cin
// ----------------------------------------------------------------------------
module somador_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop;   // a ^ b
  logic gen;    // a & b
  logic pass;   // (a ^ b) & cin

  xor u_x_prop (prop, a, b);
  xor u_x_sum  (s, prop, cin);
  and u_a_gen  (gen, a, b);
  and u_a_pass (pass, prop, cin);
  or  u_o_cout (cout, gen, pass);

endmodule : somador_bit

// File: rtl/somador_serial_ctrl.sv
// ----------------------------------------------------------------------------
// somador_serial_ctrl
//
// Bit-serial add/subtract unit. One full-adder cell (somador_bit) is walked
// over WIDTH clock cycles, LSB first, with a registered carry. Subtraction is
// a + ~b + 1: B is inverted at load time and the carry flop is preset to 1.
//
// Parameters:
//   WIDTH     operand width in bits, legal range 2..64
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request; sampled only in IDLE
//   sub       in   0 = a+b, 1 = a-b; sampled with start
//   a, b      in   operands; sampled with start
//   busy      out  high while in RUN
//   done      out  one-cycle pulse; result/cout/overflow valid
//   result    out  sum/difference
//   cout      out  carry out of MSB (sub: 1 = no borrow, a >= b unsigned)
//   overflow  out  signed overflow (carry into MSB ^ carry out of MSB)
//
// Timing: start sampled at E0, bits 0..WIDTH-1 processed at E1..E_WIDTH,
// done in the cycle after E_WIDTH. One op per WIDTH+2 cycles.
// ----------------------------------------------------------------------------
module somador_serial_ctrl
  import somador_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  // The counter exits at WIDTH-1, so it never needs to represent WIDTH.
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mc_state_e        state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;       // operand A shift register
  logic [WIDTH-1:0] b_q,      b_d;       // operand B (pre-inverted for sub)
  logic [WIDTH-1:0] result_q, result_d;  // sum fills from the MSB side
  logic [CNT_W-1:0] count_q,  count_d;   // bit index being processed
  logic             carry_q,  carry_d;   // carry into the current bit
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  // Full-adder cell outputs for the current bit.
  logic fa_s;
  logic fa_co;

  somador_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that paths
    // which do not assign it hold state instead of inferring a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;          // the +1 of two's-complement negation
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum enters at the MSB; after WIDTH shifts bit 0 sits at result[0].
        // Result is only touched here, so it holds between operations.
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = fa_co;
        if (count_q == LAST) begin
          // carry_q is the carry into the MSB on this final step.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Start is ignored here; the next request is taken in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the datapath registers are reset along with the FSM so that an
  // aborted operation leaves visibly cleared result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded straight from registers, no input-to-output paths.
  // --------------------------------------------------------------------------
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : somador_serial_ctrl

// File: tb/tb_somador_serial_ctrl.sv
// ----------------------------------------------------------------------------
// tb_somador_serial_ctrl
//
// Self-checking bench for somador_serial_ctrl at WIDTH=8: directed vectors,
// randomized operations against an integer-arithmetic reference model, a
// held-start handshake sequence and an asynchronous mid-operation reset.
// ----------------------------------------------------------------------------
module tb_somador_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  somador_serial_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] e_res;
    logic         e_cout;
    logic         e_ovf;
    string        name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                         input logic [W-1:0] mb,
                                         input logic ms);
    int ua, ub, sa, sb, ur, sr;
    logic [W-1:0] r;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      ur = ua + ub;
      sr = sa + sb;
      co = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end
    r  = ur[W-1:0];
    ov = (sr > 127) || (sr < -128);
    return {ov, co, r};
  endfunction

  // Runs one operation starting from IDLE, one time unit after a rising edge.
  // Operands are scrambled right after E0 to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [W-1:0] e_res,
                        input logic e_co, input logic e_ov, input string name);
    int lat;
    int busy_cnt;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = 0;
    busy_cnt = int'(busy);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done) busy_cnt += int'(busy);
    end
    check({name, " latency"}, 64'(lat), 64'(W));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " result"}, 64'(result), 64'(e_res));
    check({name, " cout"}, 64'(cout), 64'(e_co));
    check({name, " overflow"}, 64'(overflow), 64'(e_ov));
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rs;
    int d1, d2, spurious;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "add_nocarry"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap"};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf"};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow"};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf"};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_negovf"};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero"};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].e_res,
             vecs[i].e_cout, vecs[i].e_ovf, vecs[i].name);

    // Randomized operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      m  = model(ra, rb, rs);
      run_op(ra, rb, rs, m[W-1:0], m[W], m[W+1], "random");
    end

    // Handshake: start held high across two operations.
    a = 8'h3C; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;              // E0 of first op
    a = 8'h10; b = 8'h03; sub = 1'b1; // second op operands; start stays high
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          check("hs op1 result", 64'(result), 64'h4B);
          check("hs op1 cout", 64'(cout), 64'd0);
          check("hs op1 overflow", 64'(overflow), 64'd0);
        end else if (d2 < 0) begin
          d2 = k;
          start = 1'b0;
          check("hs op2 result", 64'(result), 64'h0D);
          check("hs op2 cout", 64'(cout), 64'd1);
          check("hs op2 overflow", 64'(overflow), 64'd0);
        end
      end
      if (k == 5) check("hs busy mid run", 64'(busy), 64'd1);
      if (k == 9) begin
        check("hs idle after done", 64'(busy), 64'd0);
        check("hs result hold idle", 64'(result), 64'h4B);
      end
      if (k == 10) begin
        check("hs op2 accepted", 64'(busy), 64'd1);
        check("hs result hold E0", 64'(result), 64'h4B);
      end
    end
    start = 1'b0;
    check("hs done1 position", 64'(d1), 64'd8);
    check("hs done spacing", 64'(d2 - d1), 64'd10);

    // Mid-operation asynchronous reset, with nonzero flags beforehand.
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "pre_reset");
    a = 8'h3C; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end   // E1..E4
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort cout", 64'(cout), 64'd0);
    check("abort overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      spurious += int'(done) + int'(busy);
    end
    check("abort no done", 64'(spurious), 64'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_somador_serial_ctrl

// File: doc/somador_serial_ctrl.md
# somador_serial_ctrl

Bit-serial add/subtract unit for the MIPS datapath. It sequences a single 1-bit full adder over WIDTH clock cycles, LSB first, with a registered carry, and exposes a start/busy/done handshake. It gives low-area ALU ops and multi-cycle-capable instructions a word-wide adder/subtractor built from one full-adder cell.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result/cout/overflow valid.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB (sub: 1 = no borrow, a ≥ b unsigned).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, load shift regs A←a, B←(sub ? ~b : b), carry←sub, count←0 → RUN. start=0 stays IDLE.
- RUN, each cycle: full adder on A[0], B[0], carry; sum shifted into result MSB (result shifts right); A, B shift right; carry←fa cout; count++.
- Last step (count == WIDTH−1): cout←fa cout; overflow←carry (carry into MSB) XOR fa cout; → DONE.
- DONE: done=1 for exactly this cycle → IDLE unconditionally.
- start while RUN or DONE is ignored; no queuing. A held-high start is accepted on the first IDLE cycle.
- a, b and sub may change freely after the sampling edge.
- result, cout, overflow hold their values from DONE until the first RUN edge of the next accepted operation.
- Reset (any state, including mid-RUN): state←IDLE; result, cout, overflow, carry, count, shift regs ←0; busy=0, done=0. No done pulse for an aborted op.

## Timing
- E0 = edge sampling start=1 in IDLE. Edges E1..E_WIDTH process bits 0..WIDTH−1.
- busy high from after E0 until E_WIDTH.
- done high in the cycle after E_WIDTH. Latency: WIDTH+1 cycles from start to done. Throughput: one op per WIDTH+2 cycles.
- busy and done are decoded from the state register: no combinational path from inputs to outputs.
- count width $clog2(WIDTH); no wrap, because the exit happens at WIDTH−1.

## Structure
- Shared package/header holds the state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10. It is reused by other multi-cycle datapath controllers.
- One sub-module, somador_bit: structural 1-bit full adder with ports a, b, cin → s, cout, made of xor/and/or gates. Instantiate it exactly once.
- Everything else lives in this module: FSM, counter, shift registers, carry flop and flag capture.

## Test plan
All cases use WIDTH=8.
- Add, no carry: 8'h3C + 8'h0F → result 8'h4B, cout 0, overflow 0. done high in the cycle after E8; busy high from after E0 through E8.
- Add, unsigned wrap: 8'hFF + 8'h01 → 8'h00, cout 1, overflow 0.
- Add, signed overflow: 8'h7F + 8'h01 → 8'h80, cout 0, overflow 1.
- Subtract, borrow: sub=1, 8'h05 − 8'h07 → 8'hFE, cout 0, overflow 0.
- Subtract, signed overflow: sub=1, 8'h80 − 8'h01 → 8'h7F, cout 1, overflow 1.
- Handshake, start held high across two ops with operands changed after E0:
  - first op's result is unaffected by the operand change;
  - start is ignored during RUN and DONE;
  - second op is accepted on the first IDLE edge after DONE, so done pulses are 10 cycles apart;
  - result holds between ops.
- Reset mid-op: assert rst_n=0 asynchronously between E4 and E5.
  - busy, done, result, cout and overflow drop to 0 immediately;
  - after release, no done pulse appears;
  - a fresh 8'h01 + 8'h01 returns 8'h02.
